instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Small synchronous FIFO of {pc, instruction} pairs between the fetch stage (pc_reg + instruction_memory) and the decode stage. It decouples fetch from decode stalls, drives the PC register enable so fetch stops when the queue is full, and discards all queued instructions on a branch/jump redirect. It presents a canonical NOP to decode whenever no valid instruction is available.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- XLEN, 32, width of the PC and instruction fields
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- push  in  1  fetch presents a valid pair this cycle
- push_pc  in  XLEN  PC of the pushed instruction
- push_instr  in  XLEN  instruction word read from instruction_memory
- fetch_en  out  1  enable for pc_reg; high when the queue can accept a push
- pop  in  1  decode consumes the head entry this cycle
- out_valid  out  1  head entry is valid
- out_pc  out  XLEN  PC of the head entry
- out_instr  out  XLEN  head instruction; NOP when empty
- flush  in  1  redirect; discard all entries
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky error: a push was attempted while full

## Operation
- Storage: circular buffer with head pointer, tail pointer and an occupancy counter, all registered.
- Push is accepted when `push && count != DEPTH`. The pair is written at tail, tail advances, and count increments.
- A push while full is dropped and sets overflow. No state other than overflow changes.
- Pop is accepted when `pop && count != 0`. Head advances and count decrements. A pop while empty is ignored and is not an error.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance.
- Push and pop in the same cycle while full: the push is rejected, because the full check uses the pre-edge count. The pop proceeds.
- Push and pop in the same cycle while empty: the pop is ignored, the push is accepted, and count becomes 1. There is no bypass path.
- Flush has the highest priority. At the next edge head = tail = 0, count = 0 and overflow clears. Any push or pop in the flush cycle is discarded.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Outputs:
  - out_valid = (count != 0).
  - out_pc and out_instr come from the head entry when valid. Otherwise they are 0 and 32'h00000013 (addi x0,x0,0).
  - fetch_en = !rst && (count != DEPTH).

## Timing
- All state updates on the rising edge of clk. All outputs depend only on registered state, plus rst for fetch_en.
- Latency: a pair pushed in cycle N is visible on out_* in cycle N+1.
- Reset, also valid mid-operation:
  - Same effect as flush: count = 0, pointers = 0, overflow = 0.
  - After the reset edge: out_valid = 0, out_pc = 0, out_instr = NOP.
  - fetch_en is 0 while rst is high and 1 in the first cycle after it is released.
- Storage contents are not reset. Entries are only observed through valid pointers.
- Full: fetch_en falls in the cycle after the edge where count reaches DEPTH. It rises in the cycle after the first accepted pop.

## Structure
- The shared riscv_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h00000013
  - the default queue DEPTH
- No sub-module: pointers, counter and storage fit in a single module.
- The decode stage and the hazard unit import NOP_INSTR from the same package.

## Test plan
- Reset then idle:
  - Assert rst for 3 cycles, release.
  - Required: out_valid = 0, out_instr = 32'h00000013, count = 0, fetch_en = 1; fetch_en = 0 during rst.
- Fill:
  - Push pc = 0, 4, 8, 12 on consecutive cycles with pop = 0.
  - Required: count = 4, fetch_en = 0, out_pc = 0.
  - A 5th push sets overflow = 1 and count stays 4.
- Drain in order:
  - From full, pop 4 cycles.
  - Required: out_pc sequence 0, 4, 8, 12, then out_valid = 0 and out_instr = NOP. A further pop leaves count at 0.
- Steady streaming:
  - Push and pop every cycle for 10 cycles starting from count = 1.
  - Required: count stays 1, each out_pc lags push_pc by one entry, pointers wrap past 3 with no corruption.
- Flush:
  - With count = 3, assert flush together with push = 1 and pop = 1.
  - Required next cycle: count = 0, out_valid = 0, overflow = 0. The next push after flush appears one cycle later.
- Reset mid-operation:
  - With count = 2 and overflow = 1, assert rst with push = 1.
  - Required: count = 0, overflow = 0, out_valid = 0, fetch_en = 0 during rst.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared core constants: datapath width, canonical NOP and
//                the default instruction fetch queue depth.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam int          XLEN              = 32;
   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
   localparam int          FETCH_QUEUE_DEPTH = 4;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Circular FIFO of {pc, instruction} pairs between fetch and
//                decode, with full back-pressure, redirect flush and NOP fill.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
   parameter int DEPTH = riscv_pkg::FETCH_QUEUE_DEPTH,
   parameter int XLEN  = riscv_pkg::XLEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [XLEN-1:0]          push_pc,
   input  logic [XLEN-1:0]          push_instr,
   output logic                     fetch_en,
   input  logic                     pop,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   import riscv_pkg::*;

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);

   logic [XLEN-1:0]    r_mem_pc    [DEPTH];
   logic [XLEN-1:0]    r_mem_instr [DEPTH];
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [c_CNT_W-1:0] r_count;
   logic               r_overflow;

   logic               w_full;
   logic               w_empty;
   logic               w_push_ok;
   logic               w_pop_ok;
   logic               w_clear;

   // Full/empty use the pre-edge count, so push-while-full is rejected even
   // when a pop frees a slot in the same cycle, and there is no bypass path.
   assign w_full    = (r_count == c_FULL);
   assign w_empty   = (r_count == '0);
   assign w_push_ok = push && !w_full;
   assign w_pop_ok  = pop && !w_empty;
   assign w_clear   = rst || flush;

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_tail <= r_tail + c_PTR_1;
         end
         if (w_pop_ok) begin
            r_head <= r_head + c_PTR_1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + c_CNT_1;
            2'b01:   r_count <= r_count - c_CNT_1;
            default: r_count <= r_count;
         endcase
         if (push && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately not reset; entries are only read through head.
   always_ff @(posedge clk) begin
      if (!w_clear && w_push_ok) begin
         r_mem_pc[r_tail]    <= push_pc;
         r_mem_instr[r_tail] <= push_instr;
      end
   end

   always_comb begin
      out_valid = !w_empty;
      out_pc    = '0;
      out_instr = XLEN'(NOP_INSTR);
      if (!w_empty) begin
         out_pc    = r_mem_pc[r_head];
         out_instr = r_mem_instr[r_head];
      end
   end

   assign fetch_en = !rst && !w_full;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule : instr_fetch_queue

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Directed bench with a queue-based reference model compared
//                every cycle, plus literal expectations for each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0;
   logic [31:0] push_pc = '0;
   logic [31:0] push_instr = '0;
   logic        fetch_en;
   logic        pop = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        flush = 1'b0;
   logic [2:0]  count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_pc    (push_pc),
      .push_instr (push_instr),
      .fetch_en   (fetch_en),
      .pop        (pop),
      .out_valid  (out_valid),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .flush      (flush),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pairs plus a sticky error bit
   logic [31:0] m_pc[$];
   logic [31:0] m_instr[$];
   bit          m_ovf = 1'b0;
   bit          m_started = 1'b0;

   always @(posedge clk) begin
      bit was_full, was_empty;
      m_started = 1'b1;
      if (rst || flush) begin
         m_pc.delete();
         m_instr.delete();
         m_ovf = 1'b0;
      end else begin
         was_full  = (m_pc.size() == DEPTH);
         was_empty = (m_pc.size() == 0);
         if (pop && !was_empty) begin
            void'(m_pc.pop_front());
            void'(m_instr.pop_front());
         end
         if (push && !was_full) begin
            m_pc.push_back(push_pc);
            m_instr.push_back(push_instr);
         end else if (push) begin
            m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("mdl_count", 32'(count), 32'(m_pc.size()));
         check("mdl_valid", 32'(out_valid), 32'(m_pc.size() != 0));
         check("mdl_pc", out_pc, (m_pc.size() != 0) ? m_pc[0] : 32'h0);
         check("mdl_instr", out_instr, (m_pc.size() != 0) ? m_instr[0] : NOP);
         check("mdl_fetch_en", 32'(fetch_en), 32'(!rst && (m_pc.size() != DEPTH)));
         check("mdl_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic cyc(input logic p, input logic [31:0] pc, input logic o, input logic f);
      push       = p;
      push_pc    = pc;
      push_instr = pc ^ 32'h00A0_0093;
      pop        = o;
      flush      = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset then idle
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b0);
         check("rst_fetch_en", 32'(fetch_en), 32'h0);
      end
      rst = 1'b0;
      #1;
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_instr", out_instr, NOP);
      check("idle_count", 32'(count), 32'h0);
      check("idle_fetch_en", 32'(fetch_en), 32'h1);

      // Fill to DEPTH, then one overflowing push
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(4 * i), 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'h4);
      check("fill_fetch_en", 32'(fetch_en), 32'h0);
      check("fill_pc", out_pc, 32'h0);
      cyc(1'b1, 32'h10, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 32'h1);
      check("ovf_count", 32'(count), 32'h4);

      // Drain in order
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", out_pc, 32'(4 * i));
         check("drain_instr", out_instr, 32'(4 * i) ^ 32'h00A0_0093);
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
         if (i == 0) check("drain_fetch_en", 32'(fetch_en), 32'h1);
      end
      check("drain_valid", 32'(out_valid), 32'h0);
      check("drain_nop", out_instr, NOP);
      check("drain_pc0", out_pc, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      check("empty_pop_count", 32'(count), 32'h0);

      // Push+pop while empty: push wins, no bypass
      cyc(1'b1, 32'h100, 1'b1, 1'b0);
      check("empty_pp_count", 32'(count), 32'h1);
      check("empty_pp_pc", out_pc, 32'h100);

      // Streaming at count = 1 across pointer wrap
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 32'h104 + 32'(4 * i), 1'b1, 1'b0);
         check("stream_count", 32'(count), 32'h1);
         check("stream_pc", out_pc, 32'h104 + 32'(4 * i));
      end

      // Flush with push and pop at count = 3
      cyc(1'b1, 32'h180, 1'b0, 1'b0);
      cyc(1'b1, 32'h184, 1'b0, 1'b0);
      check("preflush_count", 32'(count), 32'h3);
      cyc(1'b1, 32'h188, 1'b1, 1'b1);
      check("flush_count", 32'(count), 32'h0);
      check("flush_valid", 32'(out_valid), 32'h0);
      check("flush_ovf", 32'(overflow), 32'h0);
      cyc(1'b1, 32'h200, 1'b0, 1'b0);
      check("postflush_valid", 32'(out_valid), 32'h1);
      check("postflush_pc", out_pc, 32'h200);

      // Full with push+pop: push rejected, pop proceeds
      for (int i = 1; i < 4; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      cyc(1'b1, 32'h300, 1'b0, 1'b0);
      check("ovf2_set", 32'(overflow), 32'h1);
      cyc(1'b1, 32'h304, 1'b1, 1'b0);
      check("full_pp_count", 32'(count), 32'h3);
      check("full_pp_pc", out_pc, 32'h204);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      check("pre_rst_count", 32'(count), 32'h2);
      check("pre_rst_pc", out_pc, 32'h208);

      // Reset mid-operation with a push pending
      rst = 1'b1;
      #1;
      check("midrst_fetch_en", 32'(fetch_en), 32'h0);
      cyc(1'b1, 32'h400, 1'b0, 1'b0);
      check("midrst_count", 32'(count), 32'h0);
      check("midrst_ovf", 32'(overflow), 32'h0);
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_instr", out_instr, NOP);
      check("midrst_fetch_en2", 32'(fetch_en), 32'h0);
      rst = 1'b0;
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      check("post_rst_fetch_en", 32'(fetch_en), 32'h1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instr_fetch_queue

`default_nettype wire
